// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphonic voice allocator: per-voice and controller
// state encodings plus the default note width.
package synth_voice_pkg;

  localparam int unsigned DEFAULT_NOTE_WIDTH = 7;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    HELD      = 2'd1,
    RELEASING = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    RETRIG = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake and voice-bank outputs of the voice allocator.
// The master side is the event source, the slave side is the allocator.
interface voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_WIDTH = synth_voice_pkg::DEFAULT_NOTE_WIDTH,
  parameter int unsigned AR_WIDTH   = 32
);
  logic                             note_valid;
  logic                             note_ready;
  logic                             note_on;
  logic [NOTE_WIDTH-1:0]            note_num;
  logic [AR_WIDTH-1:0]              release_len;
  logic [NUM_VOICES-1:0]            voice_play;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note;
  logic [NUM_VOICES-1:0]            voice_active;
  logic                             note_dropped;

  modport master (
    output note_valid, note_on, note_num, release_len,
    input  note_ready, voice_play, voice_note, voice_active, note_dropped
  );

  modport slave (
    input  note_valid, note_on, note_num, release_len,
    output note_ready, voice_play, voice_note, voice_active, note_dropped
  );
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice slot: lifecycle state, assigned note, release tail counter and
// saturating age, driven by strobes from the allocator controller.
module voice_slot
  import synth_voice_pkg::*;
#(
  parameter int unsigned NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int unsigned AR_WIDTH   = 32,
  parameter int unsigned AGE_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  assign_i,
  input  logic [NOTE_WIDTH-1:0] note_i,
  input  logic                  release_i,
  input  logic [AR_WIDTH-1:0]   release_len_i,
  input  logic                  age_inc_i,
  input  logic                  play_set_i,
  input  logic                  play_clr_i,
  output voice_state_t          state_o,
  output logic [NOTE_WIDTH-1:0] note_o,
  output logic [AGE_WIDTH-1:0]  age_o,
  output logic                  play_o,
  output logic                  active_o
);

  voice_state_t          state_q, state_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [AR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [AGE_WIDTH-1:0]  age_q, age_d;
  logic                  play_q, play_d;
  logic                  active_q, active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FREE;
      note_q   <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      play_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      play_q   <= play_d;
      active_q <= active_d;
    end
  end

  // Release tail runs on its own; controller strobes override it.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    age_d   = age_q;
    play_d  = play_q;

    if (state_q == RELEASING) begin
      if (cnt_q <= AR_WIDTH'(1)) begin
        state_d = FREE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - AR_WIDTH'(1);
      end
    end

    if (age_inc_i && (state_q != FREE) && (age_q != '1)) begin
      age_d = age_q + AGE_WIDTH'(1);
    end

    if (release_i) begin
      if (release_len_i == '0) begin
        state_d = FREE;
        cnt_d   = '0;
      end else begin
        state_d = RELEASING;
        cnt_d   = release_len_i;
      end
    end

    if (assign_i) begin
      state_d = HELD;
      note_d  = note_i;
      age_d   = '0;
      cnt_d   = '0;
    end

    if (play_set_i) begin
      play_d = 1'b1;
    end else if (play_clr_i) begin
      play_d = 1'b0;
    end

    active_d = (state_d != FREE);
  end

  assign state_o  = state_q;
  assign note_o   = note_q;
  assign age_o    = age_q;
  assign play_o   = play_q;
  assign active_o = active_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans all voice slots per event, then commits a
// note-on/off. Define VOICE_STEAL_EN to steal the oldest voice when none is free.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int unsigned AR_WIDTH   = 32,
  parameter int unsigned AGE_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  voice_allocator_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ev_on_q, ev_on_d;
  logic [NOTE_WIDTH-1:0] ev_note_q, ev_note_d;
  logic                  free_vld_q, free_vld_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic                  rel_vld_q, rel_vld_d;
  logic [IDX_W-1:0]      rel_idx_q, rel_idx_d;
  logic [AGE_WIDTH-1:0]  rel_age_q, rel_age_d;
  logic                  held_vld_q, held_vld_d;
  logic [IDX_W-1:0]      held_idx_q, held_idx_d;
  logic [AGE_WIDTH-1:0]  held_age_q, held_age_d;
  logic                  match_vld_q, match_vld_d;
  logic [IDX_W-1:0]      match_idx_q, match_idx_d;
  logic [IDX_W-1:0]      tgt_q, tgt_d;
  logic                  ready_q, ready_d;
  logic                  drop_q, drop_d;

  voice_state_t          slot_state [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] slot_note  [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  slot_age   [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_play, slot_active;
  logic [NUM_VOICES-1:0] assign_v, release_v, age_inc_v, play_set_v, play_clr_v;

  voice_state_t          cur_state;
  logic [NOTE_WIDTH-1:0] cur_note;
  logic [AGE_WIDTH-1:0]  cur_age;
  logic                  tgt_vld_c, tgt_held_c;
  logic [IDX_W-1:0]      tgt_idx_c;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(
      .NOTE_WIDTH (NOTE_WIDTH),
      .AR_WIDTH   (AR_WIDTH),
      .AGE_WIDTH  (AGE_WIDTH)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .assign_i      (assign_v[v]),
      .note_i        (ev_note_q),
      .release_i     (release_v[v]),
      .release_len_i (bus.release_len),
      .age_inc_i     (age_inc_v[v]),
      .play_set_i    (play_set_v[v]),
      .play_clr_i    (play_clr_v[v]),
      .state_o       (slot_state[v]),
      .note_o        (slot_note[v]),
      .age_o         (slot_age[v]),
      .play_o        (slot_play[v]),
      .active_o      (slot_active[v])
    );
    assign bus.voice_note[v*NOTE_WIDTH +: NOTE_WIDTH] = slot_note[v];
  end

  assign cur_state = slot_state[idx_q];
  assign cur_note  = slot_note[idx_q];
  assign cur_age   = slot_age[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      rel_vld_q   <= 1'b0;
      rel_idx_q   <= '0;
      rel_age_q   <= '0;
      held_vld_q  <= 1'b0;
      held_idx_q  <= '0;
      held_age_q  <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      tgt_q       <= '0;
      ready_q     <= 1'b1;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      rel_vld_q   <= rel_vld_d;
      rel_idx_q   <= rel_idx_d;
      rel_age_q   <= rel_age_d;
      held_vld_q  <= held_vld_d;
      held_idx_q  <= held_idx_d;
      held_age_q  <= held_age_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      tgt_q       <= tgt_d;
      ready_q     <= ready_d;
      drop_q      <= drop_d;
    end
  end

  // Note-on target: free first; stealing falls back to oldest releasing, then oldest held.
  always_comb begin
    tgt_vld_c  = 1'b0;
    tgt_held_c = 1'b0;
    tgt_idx_c  = '0;
    if (free_vld_q) begin
      tgt_vld_c = 1'b1;
      tgt_idx_c = free_idx_q;
    end
`ifdef VOICE_STEAL_EN
    else if (rel_vld_q) begin
      tgt_vld_c = 1'b1;
      tgt_idx_c = rel_idx_q;
    end else if (held_vld_q) begin
      tgt_vld_c  = 1'b1;
      tgt_held_c = 1'b1;
      tgt_idx_c  = held_idx_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_on_d     = ev_on_q;
    ev_note_d   = ev_note_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    rel_vld_d   = rel_vld_q;
    rel_idx_d   = rel_idx_q;
    rel_age_d   = rel_age_q;
    held_vld_d  = held_vld_q;
    held_idx_d  = held_idx_q;
    held_age_d  = held_age_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    tgt_d       = tgt_q;
    drop_d      = 1'b0;
    assign_v    = '0;
    release_v   = '0;
    age_inc_v   = '0;
    play_set_v  = '0;
    play_clr_v  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.note_valid && ready_q) begin
          ev_on_d     = bus.note_on;
          ev_note_d   = bus.note_num;
          idx_d       = '0;
          free_vld_d  = 1'b0;
          rel_vld_d   = 1'b0;
          held_vld_d  = 1'b0;
          match_vld_d = 1'b0;
          state_d     = SCAN;
        end
      end

      SCAN: begin
        if ((cur_state == FREE) && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if ((cur_state == RELEASING) && (!rel_vld_q || (cur_age > rel_age_q))) begin
          rel_vld_d = 1'b1;
          rel_idx_d = idx_q;
          rel_age_d = cur_age;
        end
        if ((cur_state == HELD) && (!held_vld_q || (cur_age > held_age_q))) begin
          held_vld_d = 1'b1;
          held_idx_d = idx_q;
          held_age_d = cur_age;
        end
        if ((cur_state == HELD) && !match_vld_q && (cur_note == ev_note_q)) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (!ev_on_q) begin
          if (match_vld_q) begin
            release_v[match_idx_q]  = 1'b1;
            play_clr_v[match_idx_q] = 1'b1;
          end
        end else if (!match_vld_q) begin
          if (tgt_vld_c) begin
            assign_v[tgt_idx_c] = 1'b1;
            age_inc_v           = ~(NUM_VOICES'(1) << tgt_idx_c);
            if (tgt_held_c) begin
              play_clr_v[tgt_idx_c] = 1'b1;
              tgt_d                 = tgt_idx_c;
              state_d               = RETRIG;
            end else begin
              play_set_v[tgt_idx_c] = 1'b1;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end

`ifdef VOICE_STEAL_EN
      // Gate was dropped at commit; raising it again restarts the envelope attack.
      RETRIG: begin
        play_set_v[tgt_q] = 1'b1;
        state_d           = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.note_ready   = ready_q;
  assign bus.note_dropped = drop_q;
  assign bus.voice_play   = slot_play;
  assign bus.voice_active = slot_active;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with 4 voices: a table of note events with
// expected voice outputs, plus hand-written timing, release, steal/drop and reset sequences.
module tb_voice_allocator;

  localparam int unsigned NV = 4;
  localparam int unsigned NW = 7;
  localparam int unsigned AW = 32;
  localparam int unsigned GW = 8;

  typedef struct {
    logic            on;
    logic [NW-1:0]   num;
    logic [NV-1:0]   play;
    logic [NV-1:0]   active;
    logic [NV*NW-1:0] notes;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .AR_WIDTH(AW)) bus ();

  voice_allocator #(
    .NUM_VOICES (NV),
    .NOTE_WIDTH (NW),
    .AR_WIDTH   (AW),
    .AGE_WIDTH  (GW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [NV*NW-1:0] notes4(input logic [NW-1:0] n3, input logic [NW-1:0] n2,
                                              input logic [NW-1:0] n1, input logic [NW-1:0] n0);
    return {n3, n2, n1, n0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [NV-1:0] play, input logic [NV-1:0] active,
                           input logic [NV*NW-1:0] notes, input logic drop, input logic ready);
    check({tag, ".play"},   32'(bus.voice_play),   32'(play));
    check({tag, ".active"}, 32'(bus.voice_active), 32'(active));
    check({tag, ".notes"},  32'(bus.voice_note),   32'(notes));
    check({tag, ".drop"},   32'(bus.note_dropped), 32'(drop));
    check({tag, ".ready"},  32'(bus.note_ready),   32'(ready));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.note_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the falling edge of cycle 1 (event accepted at the preceding rising edge).
  task automatic send(input logic on, input logic [NW-1:0] num);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.note_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: note_ready=%b, expected 1", bus.note_ready);
    end
    bus.note_valid = 1'b1;
    bus.note_on    = on;
    bus.note_num   = num;
    @(posedge clk);
    @(negedge clk);
    bus.note_valid = 1'b0;
  endtask

  vec_t tbl [12];

  initial begin
    int n;
    rst             = 1'b1;
    bus.note_valid  = 1'b0;
    bus.note_on     = 1'b0;
    bus.note_num    = '0;
    bus.release_len = 32'd10;

    tbl[0]  = '{1'b1, 7'd60, 4'b0001, 4'b0001, notes4(7'd0,  7'd0,  7'd0,  7'd60)};
    tbl[1]  = '{1'b1, 7'd62, 4'b0011, 4'b0011, notes4(7'd0,  7'd0,  7'd62, 7'd60)};
    tbl[2]  = '{1'b1, 7'd64, 4'b0111, 4'b0111, notes4(7'd0,  7'd64, 7'd62, 7'd60)};
    tbl[3]  = '{1'b0, 7'd62, 4'b0101, 4'b0101, notes4(7'd0,  7'd64, 7'd62, 7'd60)};
    tbl[4]  = '{1'b1, 7'd60, 4'b0101, 4'b0101, notes4(7'd0,  7'd64, 7'd62, 7'd60)};
    tbl[5]  = '{1'b0, 7'd99, 4'b0101, 4'b0101, notes4(7'd0,  7'd64, 7'd62, 7'd60)};
    tbl[6]  = '{1'b1, 7'd67, 4'b0111, 4'b0111, notes4(7'd0,  7'd64, 7'd67, 7'd60)};
    tbl[7]  = '{1'b1, 7'd70, 4'b1111, 4'b1111, notes4(7'd70, 7'd64, 7'd67, 7'd60)};
    tbl[8]  = '{1'b0, 7'd60, 4'b1110, 4'b1110, notes4(7'd70, 7'd64, 7'd67, 7'd60)};
    tbl[9]  = '{1'b0, 7'd67, 4'b1100, 4'b1100, notes4(7'd70, 7'd64, 7'd67, 7'd60)};
    tbl[10] = '{1'b1, 7'd61, 4'b1101, 4'b1101, notes4(7'd70, 7'd64, 7'd67, 7'd61)};
    tbl[11] = '{1'b0, 7'd64, 4'b1001, 4'b1001, notes4(7'd70, 7'd64, 7'd67, 7'd61)};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset", 4'b0000, 4'b0000, '0, 1'b0, 1'b1);

    // First note-on: nothing visible at cycle 5, voice 0 playing at cycle 6.
    send(1'b1, 7'd60);
    repeat (4) @(negedge clk);
    check("first_on.c5_play",  32'(bus.voice_play), 32'h0);
    check("first_on.c5_ready", 32'(bus.note_ready), 32'h0);
    @(negedge clk);
    check_all("first_on.c6", 4'b0001, 4'b0001, notes4(7'd0, 7'd0, 7'd0, 7'd60), 1'b0, 1'b1);

    // Release tail of exactly release_len cycles after the note-off commit.
    send(1'b1, 7'd62);
    send(1'b1, 7'd64);
    send(1'b0, 7'd62);
    repeat (4) @(negedge clk);
    check("off.c5_play", 32'(bus.voice_play), 32'b0111);
    @(negedge clk);
    check("off.c6_play",   32'(bus.voice_play),   32'b0101);
    check("off.c6_active", 32'(bus.voice_active), 32'b0111);
    n = 0;
    while (bus.voice_active[1] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("release_tail_cycles", 32'(n), 32'd10);
    check("release_tail_active", 32'(bus.voice_active), 32'b0101);

    // Table phase: zero release length, so note-offs free the voice at commit.
    do_reset();
    bus.release_len = 32'd0;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].on, tbl[i].num);
      repeat (5) @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].play, tbl[i].active, tbl[i].notes, 1'b0, 1'b1);
    end

    // All voices held, then one more note-on.
    do_reset();
    bus.release_len = 32'd10;
    send(1'b1, 7'd60);
    send(1'b1, 7'd61);
    send(1'b1, 7'd62);
    send(1'b1, 7'd63);
    repeat (5) @(negedge clk);
    check("full.play", 32'(bus.voice_play), 32'b1111);
    send(1'b1, 7'd70);
    repeat (4) @(negedge clk);
    check("full.c5_drop", 32'(bus.note_dropped), 32'h0);
    check("full.c5_play", 32'(bus.voice_play),   32'b1111);
    @(negedge clk);
`ifdef VOICE_STEAL_EN
    check_all("steal.c6", 4'b1110, 4'b1111, notes4(7'd63, 7'd62, 7'd61, 7'd70), 1'b0, 1'b0);
    @(negedge clk);
    check_all("steal.c7", 4'b1111, 4'b1111, notes4(7'd63, 7'd62, 7'd61, 7'd70), 1'b0, 1'b1);
`else
    check_all("drop.c6", 4'b1111, 4'b1111, notes4(7'd63, 7'd62, 7'd61, 7'd60), 1'b1, 1'b1);
    @(negedge clk);
    check_all("drop.c7", 4'b1111, 4'b1111, notes4(7'd63, 7'd62, 7'd61, 7'd60), 1'b0, 1'b1);
`endif

    // Reset during SCAN discards the in-flight event.
    do_reset();
    send(1'b1, 7'd60);
    send(1'b1, 7'd61);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("rst_scan.async", 4'b0000, 4'b0000, '0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_all("rst_scan.after", 4'b0000, 4'b0000, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
